fetch_unit: RTL

- Instruction fetch stage directly upstream of the control decoder.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions in a small FIFO and presents each instruction to the decoder with its pre-sliced fields: opcode, func3, func7, rd, rs1, rs2.
- Accepts a PC redirect from the branch/jump resolution logic and discards any stale in-flight fetches.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response channel.
// master = fetch side (issues requests), slave = memory side.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the control decoder.
// Holds the PC, issues word fetches with a credit limit of FIFO_DEPTH
// (buffered + in flight), buffers in-order responses with their PC and
// presents pre-sliced instruction fields. A redirect reloads the PC and
// drains stale in-flight responses in FLUSH.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target ends
// in HALT (presents a NOP flagged out_misaligned) instead of RUN.
module fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  fetch_unit_if.master    imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_misaligned
);

  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW-1:0]   DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [CW1-1:0]  DEPTH_W    = CW1'(FIFO_DEPTH);
  localparam logic [PW-1:0]   PTR_ONE    = PW'(1);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'd4};

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2, ST_HALT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} state_t;
`endif

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc_d   [FIFO_DEPTH];
  logic [31:0]     fifo_data_q [FIFO_DEPTH];
  logic [31:0]     fifo_data_d [FIFO_DEPTH];
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] halt_pc_q, halt_pc_d;
`endif

  logic            req_valid;
  logic            accept;
  logic            rsp;
  logic            flush;
  logic            push;
  logic            pop;
  logic            fifo_out_valid;
  logic [CW1-1:0]  credit_used;
  logic [XLEN-1:0] redirect_target;

  assign fifo_out_valid  = (state_q == ST_RUN) && (count_q != '0);
  assign pop             = fifo_out_valid && out_ready;
  assign rsp             = imem.imem_rsp_valid;
  assign flush           = redirect_valid && (state_q != ST_BOOT);
  assign redirect_target = redirect_pc & ALIGN_MASK;

  // Next-state: request credit, PC/response-PC counters, FIFO, FSM and redirect.
  // The credit counts an entry popped this cycle as free so a full pipe keeps
  // one fetch per cycle; the sum only falls while a request waits, so an
  // asserted request never drops before acceptance.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_data_d   = fifo_data_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d    = misalign_q;
    halt_pc_d     = halt_pc_q;
`endif
    push          = 1'b0;

    credit_used = CW1'(count_q) + CW1'(outstanding_q) - CW1'(pop);
    req_valid   = (state_q == ST_RUN) && !redirect_valid && (credit_used < DEPTH_W);
    accept      = req_valid && imem.imem_req_ready;
    outstanding_d = outstanding_q + CW'(accept) - CW'(rsp);

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (accept) pc_d = pc_q + PC_STEP;
        if (rsp) begin
          push     = !flush;
          rsp_pc_d = rsp_pc_q + PC_STEP;
        end
      end
      ST_FLUSH: begin
        if (rsp) drop_cnt_d = drop_cnt_q - CW'(1'b1);
        if (drop_cnt_q == '0) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          state_d = misalign_q ? ST_HALT : ST_RUN;
`else
          state_d = ST_RUN;
`endif
        end
      end
      default: ;
    endcase

    if (push) begin
      fifo_pc_d[wr_ptr_q]   = rsp_pc_q;
      fifo_data_d[wr_ptr_q] = imem.imem_rsp_data;
      wr_ptr_d              = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    count_d = count_q + CW'(push) - CW'(pop);

    // Redirect overrides everything: FIFO cleared, in-flight fetches become drops.
    if (flush) begin
      state_d    = ST_FLUSH;
      pc_d       = redirect_target;
      rsp_pc_d   = redirect_target;
      drop_cnt_d = outstanding_q - CW'(rsp);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_d = (redirect_pc & ~ALIGN_MASK) != '0;
      halt_pc_d  = redirect_pc;
`endif
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC & ALIGN_MASK;
      rsp_pc_q      <= RESET_PC & ALIGN_MASK;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q    <= 1'b0;
      halt_pc_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_data_q   <= fifo_data_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q    <= misalign_d;
      halt_pc_q     <= halt_pc_d;
`endif
    end
  end

  // A response arriving with a full FIFO and nothing leaving would be lost.
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && (count_q == DEPTH_C)));

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = req_valid ? (pc_q & ALIGN_MASK) : '0;

  // Decoder-facing view of the FIFO head (or the HALT NOP); zero when idle.
  always_comb begin
    out_valid      = fifo_out_valid;
    out_misaligned = 1'b0;
    out_pc         = fifo_out_valid ? fifo_pc_q[rd_ptr_q]   : '0;
    out_instr      = fifo_out_valid ? fifo_data_q[rd_ptr_q] : '0;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (state_q == ST_HALT) begin
      out_valid      = 1'b1;
      out_misaligned = 1'b1;
      out_pc         = halt_pc_q;
      out_instr      = 32'h0000_0013;
    end
`endif
  end

  assign out_opcode = out_instr[6:0];
  assign out_rd     = out_instr[11:7];
  assign out_func3  = out_instr[14:12];
  assign out_rs1    = out_instr[19:15];
  assign out_rs2    = out_instr[24:20];
  assign out_func7  = out_instr[31:25];

endmodule
